wb_pipe_skid: RTL and testbench
===============================

// Module: wb_pipe_skid
// PURPOSE
//  Parametrised MEM->WB pipeline stage with a 2-entry skid buffer. Carries NCH
//  register-write channels plus one HI/LO write. Replaces the plain stage latch
//  with valid/ready flow control. Keeps the 6-bit stall vector and adds flush.
//  Sits between the memory stage and the register file / HI-LO unit.
// PARAMETERS
//  DATA_W  32  width of each wdata, hi, lo word
//  ADDR_W  5   register-file address width
//  NCH     1   number of register write channels (2 = dual-issue write-back)
//  STAGE   4   this stage's stall-vector index; STAGE+1 is the downstream bit (STAGE<=4)
// PORTS
//  clk        in   1            clock, rising edge
//  rst        in   1            synchronous, active-high reset
//  flush      in   1            drop all buffered entries (exception/branch flush)
//  stall      in   6            pipeline stall vector; bit=1 means stop
//  in_valid   in   1            upstream entry present
//  in_ready   out  1            stage can accept this cycle
//  in_wd      in   NCH*ADDR_W   per-channel destination register
//  in_wreg    in   NCH          per-channel write enable
//  in_wdata   in   NCH*DATA_W   per-channel write data
//  in_whilo   in   1            HI/LO write enable
//  in_hi      in   DATA_W       HI value
//  in_lo      in   DATA_W       LO value
//  out_valid  out  1            entry presented to write-back
//  out_ready  in   1            write-back consumes entry
//  out_wd/out_wreg/out_wdata/out_whilo/out_hi/out_lo  out  as in_*   head entry payload
//  occupancy  out  2            buffered entries, 0..2
// BEHAVIOUR
//  - Reset (rst=1 at posedge): both entries invalid, occupancy=0, out_valid=0,
//    all out_* payload 0, in_ready=1 in the first cycle after reset.
//  - accept = in_valid & in_ready & ~stall[STAGE].
//  - drain  = out_valid & out_ready & ~stall[STAGE+1].
//  - in_ready = (occupancy<2) & ~stall[STAGE]. Registered from occupancy; no
//    combinational path from out_ready.
//  - Latency: an entry accepted in cycle N is at the output in cycle N+1 when
//    the buffer is empty.
//  - FIFO order: head = main register, second = skid register.
//  - accept & ~drain: occupancy+1. drain & ~accept: occupancy-1, skid shifts to main.
//  - accept & drain at occupancy 1: new entry replaces main.
//  - accept & drain at occupancy 2: cannot happen, because in_ready=0.
//  - Bubble rule: when out_valid=0, out_wreg=0, out_whilo=0, out_wd=0,
//    out_wdata=0, out_hi=0, out_lo=0. Downstream never writes on a bubble.
//  - Legacy stall: stall[STAGE]=1 & stall[STAGE+1]=0 drains normally, and a
//    bubble follows once empty. stall[STAGE+1]=1 freezes the head entry and
//    holds out_* stable.
//  - flush=1: both entries cleared at the next edge; an accept in the same cycle
//    is discarded. Priority: rst > flush > accept/drain.
//  - Payload fields travel as one packed word; per-channel fields are independent.
//  - occupancy never exceeds 2 and never underflows. Assertion: drain implies
//    occupancy>0.
// STRUCTURE
//  - Bus widths and the NOP/Stop/WriteDisable constants come from the shared
//    de.v include. Add WbPayloadW = NCH*(ADDR_W+1+DATA_W)+1+2*DATA_W there.
//  - One sub-module: skid_buf2 #(WIDTH). Generic 2-entry valid/ready buffer with
//    flush. wb_pipe_skid packs/unpacks the payload and applies the stall masks
//    and bubble zeroing.
// TESTING
//  1. rst held 2 cycles -> out_valid=0, occupancy=0, all out_* 0, in_ready=1.
//  2. in_valid=1, wd=5, wreg=1, wdata=32'hDEADBEEF, out_ready=1 -> next cycle
//     out_valid=1, out_wd=5, out_wdata=32'hDEADBEEF; the cycle after that,
//     out_valid=0 with all payload 0.
//  3. out_ready=0, push A=1, B=2 -> occupancy=2, in_ready=0. Raise out_ready ->
//     A then B emitted in order, occupancy 2->1->0.
//  4. Entry held, stall[5]=1 for 3 cycles -> out_* stable, occupancy unchanged.
//     stall[4]=1, stall[5]=0 -> head drains, then a bubble (wreg=0, whilo=0).
//  5. occupancy=2 plus simultaneous in_valid, flush=1 -> next cycle occupancy=0,
//     out_valid=0, and the new entry is not emitted.
//  6. NCH=2: ch0 wd=3, wreg=1; ch1 wd=7, wreg=0; whilo=1, hi=1, lo=2 -> output
//     carries both channels and hi/lo unchanged, and only ch0 wreg is set.

Source files
------------

// File: rtl/wb_pipe_skid_pkg.sv
// ----------------------------------------------------------------------------
// wb_pipe_skid_pkg
// Shared definitions for the MEM->WB pipeline stage:
//   - stall-vector width and the Stop / WriteDisable constants
//   - occupancy encoding of the 2-entry skid buffer
//   - wb_payload_w(): width of the packed write-back payload word
// ----------------------------------------------------------------------------
package wb_pipe_skid_pkg;

  localparam int   STALL_W       = 6;     // one bit per pipeline stage
  localparam logic STOP          = 1'b1;  // stall-vector bit value: hold stage
  localparam logic NO_STOP       = 1'b0;
  localparam logic WRITE_DISABLE = 1'b0;  // wreg / whilo value on a bubble

  // Buffer occupancy doubles as the buffer's state encoding.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Packed payload width: per channel {wd, wreg, wdata}, plus whilo, hi, lo.
  function automatic int wb_payload_w(input int nch, input int addr_w,
                                      input int data_w);
    return nch * (addr_w + 1 + data_w) + 1 + 2 * data_w;
  endfunction

endpackage

// File: rtl/wb_pipe_skid_buf2.sv
// ----------------------------------------------------------------------------
// skid_buf2
// Generic 2-entry valid/ready buffer with synchronous flush. Entries leave in
// arrival order: main register is the head, skid register the second entry.
// in_ready depends only on registered state, so there is no combinational
// path from out_ready to in_ready.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   flush        drop both entries at the next edge (wins over push/pop)
//   in_valid     upstream entry present      in_ready   buffer not full
//   in_data      entry payload
//   out_valid    head entry present          out_ready  head consumed
//   out_data     head entry payload
//   occupancy    number of stored entries, 0..2
// ----------------------------------------------------------------------------
module skid_buf2
  import wb_pipe_skid_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  occ_e             state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             push, pop;
  logic             load_main, main_from_skid, load_skid;

  assign in_ready  = (state_q != OCC_FULL);
  assign out_valid = (state_q != OCC_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      OCC_EMPTY: begin
        if (push) begin
          load_main = 1'b1;
          state_d   = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          load_main = 1'b1;           // head leaves, newcomer takes its place
        end else if (push) begin
          load_skid = 1'b1;
          state_d   = OCC_FULL;
        end else if (pop) begin
          state_d   = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        // push cannot occur here: in_ready is low while full.
        if (pop) begin
          main_from_skid = 1'b1;
          state_d        = OCC_ONE;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
    if (flush) begin
      state_d        = OCC_EMPTY;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= OCC_EMPTY;
    else     state_q <= state_d;
  end

  // NOTE: payload registers are deliberately not reset; validity lives in
  // state_q and the consumer masks the payload whenever out_valid is low.
  always_ff @(posedge clk) begin
    if (load_main)           main_q <= in_data;
    else if (main_from_skid) main_q <= skid_q;
    if (load_skid)           skid_q <= in_data;
  end

endmodule

// File: rtl/wb_pipe_skid.sv
// ----------------------------------------------------------------------------
// wb_pipe_skid
// MEM->WB pipeline stage with a 2-entry skid buffer. Carries NCH register-file
// write channels plus one HI/LO write, under valid/ready flow control, the
// legacy 6-bit stall vector and a flush.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    drop all buffered entries
//   stall[5:0]               stall vector; bit STAGE holds intake, STAGE+1
//                            freezes the head entry
//   in_valid / in_ready      upstream handshake
//   in_wd/in_wreg/in_wdata   per-channel destination, enable, data
//   in_whilo/in_hi/in_lo     HI/LO write enable and values
//   out_valid / out_ready    write-back handshake
//   out_*                    head entry payload, all zero on a bubble
//   occupancy                buffered entries, 0..2
// ----------------------------------------------------------------------------
module wb_pipe_skid
  import wb_pipe_skid_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NCH    = 1,
  parameter int STAGE  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH*ADDR_W-1:0] in_wd,
  input  logic [NCH-1:0]        in_wreg,
  input  logic [NCH*DATA_W-1:0] in_wdata,
  input  logic                  in_whilo,
  input  logic [DATA_W-1:0]     in_hi,
  input  logic [DATA_W-1:0]     in_lo,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NCH*ADDR_W-1:0] out_wd,
  output logic [NCH-1:0]        out_wreg,
  output logic [NCH*DATA_W-1:0] out_wdata,
  output logic                  out_whilo,
  output logic [DATA_W-1:0]     out_hi,
  output logic [DATA_W-1:0]     out_lo,
  output logic [1:0]            occupancy
);

  localparam int PW = wb_payload_w(NCH, ADDR_W, DATA_W);

  logic [PW-1:0]         in_payload, head_payload;
  logic                  buf_in_valid, buf_in_ready;
  logic                  buf_out_valid, buf_out_ready;
  logic                  drain;

  logic [NCH*ADDR_W-1:0] head_wd;
  logic [NCH-1:0]        head_wreg;
  logic [NCH*DATA_W-1:0] head_wdata;
  logic                  head_whilo;
  logic [DATA_W-1:0]     head_hi, head_lo;

  assign in_payload = {in_whilo, in_hi, in_lo, in_wd, in_wreg, in_wdata};
  assign {head_whilo, head_hi, head_lo, head_wd, head_wreg, head_wdata} =
    head_payload;

  // The stall bits act as handshake masks, so the buffer itself stays generic.
  assign buf_in_valid  = in_valid  & (stall[STAGE]   != STOP);
  assign buf_out_ready = out_ready & (stall[STAGE+1] != STOP);
  assign in_ready      = buf_in_ready & (stall[STAGE] != STOP);
  assign drain         = buf_out_valid & buf_out_ready;

  skid_buf2 #(
    .WIDTH (PW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (buf_in_valid),
    .in_ready  (buf_in_ready),
    .in_data   (in_payload),
    .out_valid (buf_out_valid),
    .out_ready (buf_out_ready),
    .out_data  (head_payload),
    .occupancy (occupancy)
  );

  // Bubble zeroing: downstream never sees a write enable without a valid entry.
  always_comb begin
    out_valid = buf_out_valid;
    out_wd    = '0;
    out_wreg  = {NCH{WRITE_DISABLE}};
    out_wdata = '0;
    out_whilo = WRITE_DISABLE;
    out_hi    = '0;
    out_lo    = '0;
    if (buf_out_valid) begin
      out_wd    = head_wd;
      out_wreg  = head_wreg;
      out_wdata = head_wdata;
      out_whilo = head_whilo;
      out_hi    = head_hi;
      out_lo    = head_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!drain || occupancy != 2'd0);
      assert (occupancy <= 2'd2);
    end
  end

endmodule

// File: tb/tb_wb_pipe_skid.sv
module tb_wb_pipe_skid;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NCH   = 2;
  localparam int STAGE = 4;

  typedef struct packed {
    logic              whilo;
    logic [DW-1:0]     hi;
    logic [DW-1:0]     lo;
    logic [NCH*AW-1:0] wd;
    logic [NCH-1:0]    wreg;
    logic [NCH*DW-1:0] wdata;
  } pl_t;

  logic              clk, rst, flush, in_valid, out_ready;
  logic [5:0]        stall;
  pl_t               in_pl;
  logic              in_ready, out_valid, out_whilo;
  logic [NCH*AW-1:0] out_wd;
  logic [NCH-1:0]    out_wreg;
  logic [NCH*DW-1:0] out_wdata;
  logic [DW-1:0]     out_hi, out_lo;
  logic [1:0]        occupancy;

  wb_pipe_skid #(.DATA_W(DW), .ADDR_W(AW), .NCH(NCH), .STAGE(STAGE)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .stall     (stall),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_wd     (in_pl.wd),
    .in_wreg   (in_pl.wreg),
    .in_wdata  (in_pl.wdata),
    .in_whilo  (in_pl.whilo),
    .in_hi     (in_pl.hi),
    .in_lo     (in_pl.lo),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_wd    (out_wd),
    .out_wreg  (out_wreg),
    .out_wdata (out_wdata),
    .out_whilo (out_whilo),
    .out_hi    (out_hi),
    .out_lo    (out_lo),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an ordered list of buffered entries, capacity 2.
  pl_t q[$];
  int  checks = 0;
  int  errors = 0;
  pl_t held;

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic pl_t observed();
    pl_t p;
    p.whilo = out_whilo;
    p.hi    = out_hi;
    p.lo    = out_lo;
    p.wd    = out_wd;
    p.wreg  = out_wreg;
    p.wdata = out_wdata;
    return p;
  endfunction

  task automatic compare(input string tag);
    pl_t exp_pl;
    exp_pl = (q.size() > 0) ? q[0] : '0;
    check({tag, "_valid"}, 256'(out_valid), 256'(q.size() > 0));
    check({tag, "_occ"},   256'(occupancy), 256'(q.size()));
    check({tag, "_ready"}, 256'(in_ready),
          256'((q.size() < 2) && !stall[STAGE]));
    check({tag, "_payload"}, 256'(observed()), 256'(exp_pl));
  endtask

  // One clock: decide accept/drain from the rules, advance model, then check.
  task automatic step(input string tag);
    logic acc, drn;
    pl_t  cur;
    cur = in_pl;
    acc = in_valid && (q.size() < 2) && !stall[STAGE];
    drn = (q.size() > 0) && out_ready && !stall[STAGE+1];
    @(posedge clk);
    if (rst || flush) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(cur);
    end
    @(negedge clk);
    compare(tag);
  endtask

  function automatic pl_t mk(input logic [AW-1:0] wd0, input logic [DW-1:0] d0);
    pl_t p;
    p = '0;
    p.wd[AW-1:0]    = wd0;
    p.wreg          = 2'b01;
    p.wdata[DW-1:0] = d0;
    return p;
  endfunction

  function automatic pl_t rnd_pl();
    pl_t p;
    p.whilo = 1'($urandom);
    p.hi    = $urandom;
    p.lo    = $urandom;
    p.wd    = (NCH*AW)'($urandom);
    p.wreg  = NCH'($urandom);
    p.wdata = {$urandom, $urandom};
    return p;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    stall = 6'b0; in_pl = '0;
    @(negedge clk);

    // 1. reset held two cycles
    step("rst0");
    step("rst1");
    check("rst_occ",   256'(occupancy), 256'(0));
    check("rst_ready", 256'(in_ready),  256'(1));
    rst = 1'b0;

    // 2. single entry, one-cycle latency, then bubble
    in_valid = 1'b1; in_pl = mk(5'd5, 32'hDEADBEEF); out_ready = 1'b1;
    step("t2a");
    check("t2_wd",    256'(out_wd[AW-1:0]),    256'(5));
    check("t2_wdata", 256'(out_wdata[DW-1:0]), 256'(32'hDEADBEEF));
    in_valid = 1'b0;
    step("t2b");
    check("t2_bubble", 256'({out_valid, out_wdata, out_wreg}), 256'(0));

    // 3. fill to two, then drain in order
    out_ready = 1'b0; in_valid = 1'b1;
    in_pl = mk(5'd1, 32'hA); step("t3a");
    in_pl = mk(5'd2, 32'hB); step("t3b");
    check("t3_full_occ",   256'(occupancy), 256'(2));
    check("t3_full_ready", 256'(in_ready),  256'(0));
    check("t3_head_a",     256'(out_wd[AW-1:0]), 256'(1));
    in_valid = 1'b0; out_ready = 1'b1;
    step("t3c");
    check("t3_head_b", 256'(out_wd[AW-1:0]), 256'(2));
    step("t3d");

    // 4. downstream stall freezes head; own stall drains then bubbles
    out_ready = 1'b0; in_valid = 1'b1; in_pl = mk(5'd12, 32'h1234_5678);
    step("t4a");
    in_valid = 1'b0; out_ready = 1'b1; stall = 6'b100000;
    held = observed();
    for (int i = 0; i < 3; i++) begin
      step("t4hold");
      check("t4_stable", 256'(observed()), 256'(held));
    end
    stall = 6'b010000;
    step("t4drain");
    check("t4_bubble", 256'({out_valid, out_wreg, out_whilo}), 256'(0));
    stall = 6'b0;

    // 5. flush while full with a simultaneous accept
    out_ready = 1'b0; in_valid = 1'b1;
    in_pl = mk(5'd20, 32'h20); step("t5a");
    in_pl = mk(5'd21, 32'h21); step("t5b");
    in_pl = mk(5'd9, 32'h99); flush = 1'b1;
    step("t5flush");
    check("t5_occ", 256'(occupancy), 256'(0));
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step("t5after");
    check("t5_noemit", 256'(out_valid), 256'(0));

    // 6. dual channel with HI/LO
    in_valid = 1'b1;
    in_pl = '0;
    in_pl.wd = {5'd7, 5'd3}; in_pl.wreg = 2'b01;
    in_pl.wdata = {32'hCAFE0001, 32'h0BAD0002};
    in_pl.whilo = 1'b1; in_pl.hi = 32'd1; in_pl.lo = 32'd2;
    step("t6");
    check("t6_wd",   256'(out_wd),   256'({5'd7, 5'd3}));
    check("t6_wreg", 256'(out_wreg), 256'(2'b01));
    check("t6_hilo", 256'({out_whilo, out_hi, out_lo}),
          256'({1'b1, 32'd1, 32'd2}));
    in_valid = 1'b0;
    step("t6b");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [5:0] s;
      s = 6'($urandom) & 6'b001111;
      if ($urandom_range(0, 5) == 0) s[4] = 1'b1;
      if ($urandom_range(0, 5) == 0) s[5] = 1'b1;
      stall     = s;
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      rst       = (i == 200);
      in_pl     = rnd_pl();
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
